// File: rtl/tx_arbiter_pkg.sv
// Shared constants, lock state type and round-robin helper for the two-requester UART arbiter.
package tx_arbiter_pkg;

    localparam int          TX_ARB_NREQ = 2;
    localparam int          TX_ARB_W    = 8;
    localparam logic [7:0]  TX_ARB_NL   = 8'h0A;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Prefer the requester that did not win last time; otherwise take whichever has data.
    function automatic logic rr_pick(input logic last, input logic ne0, input logic ne1);
        if (ne0 && ne1) begin
            return ~last;
        end else if (ne0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/tx_arbiter_fifo.sv
// Byte FIFO with registered full/empty flags; a write while full is refused even if a pop happens in the same cycle.
module tx_fifo
    import tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [TX_ARB_W-1:0]      wdata_i,
    input  logic                     rd_i,
    output logic [TX_ARB_W-1:0]      rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TX_ARB_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                full_q, empty_q;
    logic                wr_ok, rd_ok;

    always_comb begin
        wr_ok    = wr_i && !full_q;
        rd_ok    = rd_i && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/tx_arbiter.sv
// Two-requester UART byte arbiter: round-robin issue, one pulse per two cycles.
// Optional line locking (keep a requester until it sends a newline) is enabled by TX_ARB_LINE_LOCK_EN.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic [7:0] w_d0,
    input  logic       w_we0,
    output logic       r_full0,
    input  logic [7:0] w_d1,
    input  logic       w_we1,
    output logic       r_full1,
    input  logic       w_tx_ready,
    output logic [7:0] r_uartdata,
    output logic       r_uartwe,
    output logic       r_gnt,
    output logic [1:0] r_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rdata0, rdata1;
    logic          empty0, empty1;
    logic [CW-1:0] cnt0, cnt1;
    logic [1:0]    ne;
    logic          opp, sel, pop0, pop1;
    logic [7:0]    issue_byte;

    logic          uartwe_q, uartwe_d;
    logic [7:0]    uartdata_q, uartdata_d;
    logic          gnt_q, gnt_d;
    logic [1:0]    ovf_q, ovf_d;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk_i   (w_clk),
        .rst_i   (w_rst),
        .wr_i    (w_we0),
        .wdata_i (w_d0),
        .rd_i    (pop0),
        .rdata_o (rdata0),
        .full_o  (r_full0),
        .empty_o (empty0),
        .count_o (cnt0)
    );

    tx_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk_i   (w_clk),
        .rst_i   (w_rst),
        .wr_i    (w_we1),
        .wdata_i (w_d1),
        .rd_i    (pop1),
        .rdata_o (rdata1),
        .full_o  (r_full1),
        .empty_o (empty1),
        .count_o (cnt1)
    );

    assign ne = {cnt1 != '0, cnt0 != '0};

`ifdef TX_ARB_LINE_LOCK_EN
    lock_state_e lock_q, lock_d;
`endif

    always_comb begin
        opp = w_tx_ready && !uartwe_q && !(empty0 && empty1);
        sel = rr_pick(gnt_q, ne[0], ne[1]);
`ifdef TX_ARB_LINE_LOCK_EN
        // The owner keeps the link while it has data; an empty owner hands over at once.
        if (lock_q == LOCK_HELD) begin
            sel = ne[gnt_q] ? gnt_q : ~gnt_q;
        end
`endif
        issue_byte = sel ? rdata1 : rdata0;
        pop0       = opp && !sel;
        pop1       = opp && sel;
        uartwe_d   = opp;
        uartdata_d = opp ? issue_byte : 8'h00;
        gnt_d      = opp ? sel : gnt_q;
        ovf_d      = ovf_q | {w_we1 & r_full1, w_we0 & r_full0};
`ifdef TX_ARB_LINE_LOCK_EN
        lock_d = lock_q;
        if (opp) begin
            lock_d = (issue_byte != TX_ARB_NL) ? LOCK_HELD : LOCK_IDLE;
        end
`endif
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            uartwe_q   <= 1'b0;
            uartdata_q <= 8'h00;
            gnt_q      <= 1'b1;
            ovf_q      <= 2'b00;
        end else begin
            uartwe_q   <= uartwe_d;
            uartdata_q <= uartdata_d;
            gnt_q      <= gnt_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef TX_ARB_LINE_LOCK_EN
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            lock_q <= LOCK_IDLE;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign r_uartwe   = uartwe_q;
    assign r_uartdata = uartdata_q;
    assign r_gnt      = gnt_q;
    assign r_ovf      = ovf_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_tx_arbiter;

    localparam int DEPTH = 8;

    logic       w_clk;
    logic       w_rst;
    logic [7:0] w_d0, w_d1;
    logic       w_we0, w_we1;
    logic       r_full0, r_full1;
    logic       w_tx_ready;
    logic [7:0] r_uartdata;
    logic       r_uartwe;
    logic       r_gnt;
    logic [1:0] r_ovf;

    tx_arbiter #(.DEPTH(DEPTH)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_d0       (w_d0),
        .w_we0      (w_we0),
        .r_full0    (r_full0),
        .w_d1       (w_d1),
        .w_we1      (w_we1),
        .r_full1    (r_full1),
        .w_tx_ready (w_tx_ready),
        .r_uartdata (r_uartdata),
        .r_uartwe   (r_uartwe),
        .r_gnt      (r_gnt),
        .r_ovf      (r_ovf)
    );

    // clock / reset
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_we;
    logic [7:0] m_data;
    logic       m_gnt;
    logic [1:0] m_ovf;
    logic       m_locked;

    logic [7:0] dut_log[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_we     = 1'b0;
        m_data   = 8'h00;
        m_gnt    = 1'b1;
        m_ovf    = 2'b00;
        m_locked = 1'b0;
    endtask

    // One clock edge of the arbiter described by its rules, using the inputs currently applied.
    task automatic model_edge();
        int s0 = q0.size();
        int s1 = q1.size();
        logic       opp;
        logic       sel;
        logic [7:0] b;
        opp = w_tx_ready && !m_we && (s0 > 0 || s1 > 0);
        if (opp) begin
            if (m_locked) begin
                sel = ((m_gnt ? s1 : s0) > 0) ? m_gnt : !m_gnt;
            end else if (s0 > 0 && s1 > 0) begin
                sel = !m_gnt;
            end else begin
                sel = (s0 > 0) ? 1'b0 : 1'b1;
            end
            b      = sel ? q1.pop_front() : q0.pop_front();
            m_we   = 1'b1;
            m_data = b;
            m_gnt  = sel;
`ifdef TX_ARB_LINE_LOCK_EN
            m_locked = (b != 8'h0A);
`endif
        end else begin
            m_we   = 1'b0;
            m_data = 8'h00;
        end
        if (w_we0) begin
            if (s0 == DEPTH) m_ovf[0] = 1'b1;
            else q0.push_back(w_d0);
        end
        if (w_we1) begin
            if (s1 == DEPTH) m_ovf[1] = 1'b1;
            else q1.push_back(w_d1);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_uartwe"},   r_uartwe,   m_we);
        check({tag, "_uartdata"}, r_uartdata, m_data);
        check({tag, "_gnt"},      r_gnt,      m_gnt);
        check({tag, "_full0"},    r_full0,    q0.size() == DEPTH);
        check({tag, "_full1"},    r_full1,    q1.size() == DEPTH);
        check({tag, "_ovf"},      r_ovf,      m_ovf);
    endtask

    // driver: apply inputs, advance one edge, compare against the model
    task automatic cycle(input string tag, input logic we0, input logic [7:0] d0,
                         input logic we1, input logic [7:0] d1, input logic rdy);
        w_we0 = we0; w_d0 = d0; w_we1 = we1; w_d1 = d1; w_tx_ready = rdy;
        model_edge();
        @(posedge w_clk);
        #1;
        check_outputs(tag);
        if (r_uartwe === 1'b1) dut_log.push_back(r_uartdata);
    endtask

    task automatic do_reset();
        w_we0 = 1'b0; w_we1 = 1'b0; w_d0 = 8'h00; w_d1 = 8'h00; w_tx_ready = 1'b0;
        w_rst = 1'b1;
        model_reset();
        @(posedge w_clk);
        #1;
        check_outputs("rst");
        w_rst = 1'b0;
        dut_log.delete();
    endtask

    task automatic compare_log(input string tag);
        logic [7:0] got;
        check({tag, "_count"}, 8'(dut_log.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < dut_log.size()) ? dut_log[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), got, exp_q[i]);
        end
    endtask

    initial begin
        w_rst = 1'b1;
        w_we0 = 1'b0; w_we1 = 1'b0; w_d0 = 8'h00; w_d1 = 8'h00; w_tx_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge w_clk);
        #1;
        check_outputs("por");
        w_rst = 1'b0;

        // single byte latency
        do_reset();
        cycle("lat_wr", 1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        cycle("lat_issue", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("lat_data", r_uartdata, 8'h41);
        check("lat_gnt", r_gnt, 8'h00);
        repeat (2) cycle("lat_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // "AB" vs "xy"
        do_reset();
        cycle("rr_load", 1'b1, "A", 1'b1, "x", 1'b0);
        cycle("rr_load", 1'b1, "B", 1'b1, "y", 1'b0);
        repeat (10) cycle("rr_run", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef TX_ARB_LINE_LOCK_EN
        exp_q = '{"A", "B", "x", "y"};
`else
        exp_q = '{"A", "x", "B", "y"};
`endif
        compare_log("rr_order");

        // "AB\n" vs "xy"
        do_reset();
        cycle("nl_load", 1'b1, "A", 1'b1, "x", 1'b0);
        cycle("nl_load", 1'b1, "B", 1'b1, "y", 1'b0);
        cycle("nl_load", 1'b1, 8'h0A, 1'b0, 8'h00, 1'b0);
        repeat (12) cycle("nl_run", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef TX_ARB_LINE_LOCK_EN
        exp_q = '{"A", "B", 8'h0A, "x", "y"};
`else
        exp_q = '{"A", "x", "B", "y", 8'h0A};
`endif
        compare_log("nl_order");

        // overflow on requester 1
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            cycle("ovf_fill", 1'b0, 8'h00, 1'b1, 8'(8'h10 + i), 1'b0);
        end
        check("ovf_full1", r_full1, 8'h01);
        check("ovf_flags", r_ovf, 8'h02);
        repeat (2 * DEPTH + 4) cycle("ovf_drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
        compare_log("ovf_order");

        // write and pop together on a full FIFO
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fp_fill", 1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
        end
        check("fp_full_before", r_full0, 8'h01);
        cycle("fp_both", 1'b1, 8'hEE, 1'b0, 8'h00, 1'b1);
        check("fp_full_after", r_full0, 8'h00);
        check("fp_ovf", r_ovf, 8'h01);
        repeat (2 * DEPTH + 2) cycle("fp_drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("fp_drained_count", 8'(dut_log.size()), 8'(DEPTH));

        // random traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            logic [7:0] d0, d1;
            d0 = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            d1 = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            cycle("rand", 1'($urandom_range(0, 1)), d0, 1'($urandom_range(0, 1)), d1,
                  ($urandom_range(0, 9) < 3));
        end

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle("ar_fill", 1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b0);
        end
        cycle("ar_go", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("ar_pulse_before", r_uartwe, 8'h01);
        #3;
        w_rst = 1'b1;
        #1;
        model_reset();
        check("ar_uartwe", r_uartwe, 8'h00);
        check("ar_uartdata", r_uartdata, 8'h00);
        check("ar_full0", r_full0, 8'h00);
        check("ar_ovf", r_ovf, 8'h00);
        check("ar_gnt", r_gnt, 8'h01);
        repeat (3) begin
            @(posedge w_clk);
            #1;
            check_outputs("ar_hold");
        end
        w_rst = 1'b0;
        dut_log.delete();
        repeat (8) cycle("ar_after", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("ar_no_pulses", 8'(dut_log.size()), 8'h00);

        // random traffic after reset
        for (int i = 0; i < 200; i++) begin
            cycle("rand2", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, per-requester FIFO depth in bytes; SHALL be a power of 2, at least 2.
REQ-002 w_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 w_rst  input  1  asynchronous, active-high reset.
REQ-004 w_d0  input  8  requester-0 (console) byte.
REQ-005 w_we0  input  1  requester-0 write strobe.
REQ-006 r_full0  output  1  requester-0 FIFO full.
REQ-007 w_d1  input  8  requester-1 (debug dump) byte.
REQ-008 w_we1  input  1  requester-1 write strobe.
REQ-009 r_full1  output  1  requester-1 FIFO full.
REQ-010 w_tx_ready  input  1  UART transmitter idle.
REQ-011 r_uartdata  output  8  byte to UART; 0 when r_uartwe is low.
REQ-012 r_uartwe  output  1  one-cycle UART write pulse.
REQ-013 r_gnt  output  1  index of the requester that owns the current or last issue.
REQ-014 r_ovf  output  2  sticky per-requester overflow flags.

Function
REQ-015 A write SHALL be accepted when w_weN=1 and r_fullN=0 at the same edge; otherwise the byte SHALL be dropped and r_ovf[N] set.
REQ-016 r_fullN SHALL be registered and reflect the count after the current edge; a pop in the same cycle SHALL NOT rescue a write while full.
REQ-017 An issue opportunity SHALL be defined as w_tx_ready=1, r_uartwe=0 and at least one FIFO non-empty.
REQ-018 On an issue opportunity, the arbiter SHALL pop one byte and drive r_uartwe=1 and r_uartdata=byte in the next cycle.
REQ-019 If both FIFOs are non-empty, the arbiter SHALL grant the requester other than the last granted (round-robin); otherwise it SHALL grant the only non-empty one.
REQ-020 r_gnt SHALL update at the issue edge and hold until the next issue.
REQ-021 Latency: a byte written to an empty FIFO at edge t, with an idle link, SHALL produce r_uartwe=1 in the cycle after edge t+1.
REQ-022 Back-to-back pulses SHALL be impossible; at most one issue is allowed per two cycles.
REQ-023 Pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH, with full at DEPTH.
REQ-024 A simultaneous write and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-025 r_ovf bits SHALL clear only on reset.

Reset
REQ-026 Asserting w_rst SHALL immediately clear r_uartwe, r_uartdata, r_ovf, and all FIFO pointers and counts.
REQ-027 Reset SHALL set r_full0=r_full1=0, r_gnt=1 (so requester 0 wins first), and clear the lock.
REQ-028 A byte in flight or a partially drained FIFO at reset SHALL be discarded; no r_uartwe pulse SHALL occur during reset.
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 Macro TX_ARB_LINE_LOCK_EN defined: after issuing a byte other than 8'h0A from requester k, the arbiter SHALL lock to k.
REQ-031 While locked, only k SHALL be granted.
REQ-032 The lock SHALL release when k issues 8'h0A, or when k's FIFO is empty at an issue opportunity; in that case the other requester is granted in the same cycle.
REQ-033 Macro undefined: pure round-robin per REQ-019, with no lock state synthesized.

Structure
REQ-034 The shared package SHALL hold TX_ARB_NL = 8'h0A, the requester-count constant (2), and the byte-width constant (8).
REQ-035 One sub-module, tx_fifo (parameterised DEPTH, registered full/empty, count output), SHALL be instantiated twice.

Verification
REQ-036 Reset released, w_tx_ready=1; write 8'h41 to req0 at edge t -> r_uartwe=1, r_uartdata=8'h41 in the cycle after t+1; r_gnt=0.
REQ-037 Both FIFOs preloaded (req0 "AB", req1 "xy"), lock disabled -> issue order A,x,B,y with alternating r_gnt.
REQ-038 TX_ARB_LINE_LOCK_EN, req0 "AB\n", req1 "xy" preloaded -> order A,B,0A,x,y.
REQ-039 w_tx_ready=0; write DEPTH+1 bytes to req1 -> r_full1=1 after DEPTH writes, last byte dropped, r_ovf=2'b10; after ready, exactly DEPTH bytes issued in order.
REQ-040 Assert w_rst asynchronously mid-stream with 5 bytes queued -> r_uartwe=0 immediately, no further pulses after release, r_full0=0, r_ovf=0.
REQ-041 On a full FIFO, issue an opportunity and a write in the same cycle -> the write is dropped and r_ovf set; next cycle r_full=0 and count=DEPTH-1.
